// File: rtl/idelay_train_pkg.sv
// Shared types and constants for the IDELAYE2 tap trainer.
//   state_e      : trainer FSM states
//   DefTapBits   : default tap counter width
//   DefDataW     : default deserialized word width
//   win_len_bits : width needed to hold a window length of up to 2^tap_bits taps
package idelay_train_pkg;

    typedef enum logic [2:0] {
        StWaitRdy,
        StLoad,
        StSettle,
        StSample,
        StEval,
        StCenter,
        StDone,
        StFail
    } state_e;

    localparam int unsigned DefTapBits = 5;
    localparam int unsigned DefDataW   = 8;

    // A run can cover every tap, so the length needs one bit more than the tap index.
    function automatic int unsigned win_len_bits(int unsigned tap_bits);
        return tap_bits + 1;
    endfunction

endpackage

// File: rtl/tap_window_tracker.sv
// Tracks the current run of good taps and the best (widest, earliest on ties) run.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   clear          : zero run and best trackers
//   eval           : apply the verdict for tap this cycle
//   good           : tap produced no errors
//   tap            : tap index being evaluated
//   best_start     : first tap of best window (registered)
//   best_len       : length of best window (registered)
//   center_next    : centre of the best window including this cycle's update
//   window_ok_next : best window including this cycle's update meets MIN_WINDOW
module tap_window_tracker
    import idelay_train_pkg::*;
#(
    parameter int unsigned TAP_BITS   = DefTapBits,
    parameter int unsigned MIN_WINDOW = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                eval,
    input  logic                good,
    input  logic [TAP_BITS-1:0] tap,
    output logic [TAP_BITS-1:0] best_start,
    output logic [TAP_BITS:0]   best_len,
    output logic [TAP_BITS-1:0] center_next,
    output logic                window_ok_next
);

    localparam int unsigned LenW = win_len_bits(TAP_BITS);

    logic [TAP_BITS-1:0] run_start_q, run_start_d, best_start_q, best_start_d;
    logic [LenW-1:0]     run_len_q, run_len_d, best_len_q, best_len_d;

    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        if (clear) begin
            run_start_d  = '0;
            run_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (eval) begin
            if (good) begin
                if (run_len_q == '0) run_start_d = tap;
                run_len_d = run_len_q + 1'b1;
            end else begin
                run_len_d = '0;
            end
            // Strictly greater: an equal later run never displaces the earlier one.
            if (run_len_d > best_len_q) begin
                best_len_d   = run_len_d;
                best_start_d = run_start_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start     = best_start_q;
    assign best_len       = best_len_q;
    assign center_next    = best_start_d + TAP_BITS'(best_len_d >> 1);
    assign window_ok_next = (best_len_d >= LenW'(MIN_WINDOW));

endmodule

// File: rtl/idelay_tap_trainer.sv
// Per-lane IDELAYE2 tap trainer. Waits for IDELAYCTRL ready, sweeps every tap in VAR_LOAD
// mode against a fixed training word, then loads the centre of the widest clean window.
// Ports:
//   clk, reset_n : clock (rx_data domain), async active-low reset
//   ctrl_ready   : IDELAYCTRL RDY, asynchronous (2-flop synchronized here)
//   start        : retrain request, honoured only in DONE/FAIL
//   rx_data      : deserialized word, valid every cycle
//   tap_value    : IDELAYE2 CNTVALUEIN
//   tap_load     : IDELAYE2 LD, one-cycle pulse
//   busy         : sweep/centre in progress
//   done, fail   : training result levels
//   win_start    : first tap of best window
//   win_len      : length of best window
module idelay_tap_trainer
    import idelay_train_pkg::*;
#(
    parameter int unsigned       TAP_BITS      = DefTapBits,
    parameter int unsigned       DATA_W        = DefDataW,
    parameter logic [DATA_W-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int unsigned       SETTLE_CYCLES = 4,
    parameter int unsigned       SAMPLE_CYCLES = 16,
    parameter int unsigned       MIN_WINDOW    = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ctrl_ready,
    input  logic                start,
    input  logic [DATA_W-1:0]   rx_data,
    output logic [TAP_BITS-1:0] tap_value,
    output logic                tap_load,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [TAP_BITS-1:0] win_start,
    output logic [TAP_BITS:0]   win_len
);

    localparam int unsigned CntMax = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES
                                                                     : SAMPLE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [TAP_BITS-1:0] TapMax = '1;

    logic                rdy_meta, rdy_sync;
    state_e              state_q;
    logic [TAP_BITS-1:0] tap_q;
    logic [CntW-1:0]     cnt_q;
    logic                err_q;
    logic                ok_q;

    logic                trk_clear, trk_eval;
    logic [TAP_BITS-1:0] best_start, center_next;
    logic [TAP_BITS:0]   best_len;
    logic                window_ok_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
        end else begin
            rdy_meta <= ctrl_ready;
            rdy_sync <= rdy_meta;
        end
    end

    assign trk_clear = (state_q == StWaitRdy) && rdy_sync;
    assign trk_eval  = (state_q == StEval);

    tap_window_tracker #(
        .TAP_BITS  (TAP_BITS),
        .MIN_WINDOW(MIN_WINDOW)
    ) u_tracker (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (trk_clear),
        .eval          (trk_eval),
        .good          (!err_q),
        .tap           (tap_q),
        .best_start    (best_start),
        .best_len      (best_len),
        .center_next   (center_next),
        .window_ok_next(window_ok_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StWaitRdy;
            tap_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            ok_q      <= 1'b0;
            tap_value <= '0;
            tap_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            win_start <= '0;
            win_len   <= '0;
        end else if (!rdy_sync && (state_q != StWaitRdy)) begin
            // Controller lost calibration: abandon everything but keep the loaded tap.
            state_q  <= StWaitRdy;
            tap_load <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            tap_load <= 1'b0;
            unique case (state_q)
                StWaitRdy: begin
                    if (rdy_sync) begin
                        tap_q     <= '0;
                        tap_value <= '0;
                        tap_load  <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    state_q <= StSettle;
                end
                StSettle: begin
                    if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSample: begin
                    err_q <= err_q | (rx_data != TRAIN_PATTERN);
                    if (cnt_q == CntW'(SAMPLE_CYCLES - 1)) begin
                        state_q <= StEval;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StEval: begin
                    tap_load <= 1'b1;
                    if (tap_q == TapMax) begin
                        // Tracker exposes its post-update best so the final load lands in CENTER.
                        ok_q      <= window_ok_next;
                        tap_value <= window_ok_next ? center_next : '0;
                        state_q   <= StCenter;
                    end else begin
                        tap_q     <= tap_q + 1'b1;
                        tap_value <= tap_q + 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StCenter: begin
                    win_start <= best_start;
                    win_len   <= best_len;
                    busy      <= 1'b0;
                    done      <= ok_q;
                    fail      <= !ok_q;
                    state_q   <= ok_q ? StDone : StFail;
                end
                StDone, StFail: begin
                    if (start) begin
                        done    <= 1'b0;
                        fail    <= 1'b0;
                        state_q <= StWaitRdy;
                    end
                end
                default: state_q <= StWaitRdy;
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_tap_trainer.sv
module tb_idelay_tap_trainer;

    localparam logic [7:0] PAT = 8'h5C;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ctrl_ready = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rx_data;
    logic [4:0] tap_value;
    logic       tap_load;
    logic       busy;
    logic       done;
    logic       fail;
    logic [4:0] win_start;
    logic [5:0] win_len;

    int passed = 0;
    int total  = 0;

    // Delay-line model: taps in good_mask see the training word, others see its inverse.
    logic [31:0] good_mask = '0;
    logic [4:0]  cur_tap = '0;
    int          load_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tap_load) begin
            cur_tap  <= tap_value;
            load_cnt <= load_cnt + 1;
        end
    end

    assign rx_data = good_mask[cur_tap] ? PAT : ~PAT;

    idelay_tap_trainer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ctrl_ready(ctrl_ready),
        .start     (start),
        .rx_data   (rx_data),
        .tap_value (tap_value),
        .tap_load  (tap_load),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .win_start (win_start),
        .win_len   (win_len)
    );

    task automatic wait_result(input string name, output int loads);
        int  l0;
        bit  ok;
        l0 = load_cnt;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
        end
        loads = load_cnt - l0;
        total++;
        if (!ok) $display("FAIL %s timeout: got no done/fail, want one within 3000 cycles", name);
        else passed++;
    endtask

    task automatic retrain(input logic [31:0] mask);
        @(negedge clk);
        good_mask = mask;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (tap_value !== 5'd0) $display("FAIL rst tap_value: got %0d want 0", tap_value); else passed++;
        total++; if (tap_load !== 1'b0) $display("FAIL rst tap_load: got %0b want 0", tap_load); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst busy: got %0b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst done: got %0b want 0", done); else passed++;
        total++; if (fail !== 1'b0) $display("FAIL rst fail: got %0b want 0", fail); else passed++;
        total++; if (win_start !== 5'd0) $display("FAIL rst win_start: got %0d want 0", win_start); else passed++;
        total++; if (win_len !== 6'd0) $display("FAIL rst win_len: got %0d want 0", win_len); else passed++;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL idle_no_ready busy: got %0b want 0", busy); else passed++;
    endtask

    // Taps 10..20 good; also checks ready-to-LOAD latency and the full tap_load count.
    task automatic test_single_window();
        int loads;
        int l0;
        @(negedge clk);
        good_mask = 32'h001F_FC00;
        l0 = load_cnt;
        ctrl_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (tap_load !== 1'b0) $display("FAIL latency early load: got %0b want 0", tap_load); else passed++;
        @(posedge clk);
        #1;
        total++; if (tap_load !== 1'b1) $display("FAIL latency load: got %0b want 1", tap_load); else passed++;
        total++; if (tap_value !== 5'd0) $display("FAIL first tap: got %0d want 0", tap_value); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL busy in sweep: got %0b want 1", busy); else passed++;
        wait_result("single", loads);
        loads = load_cnt - l0;
        total++; if (win_start !== 5'd10) $display("FAIL single win_start: got %0d want 10", win_start); else passed++;
        total++; if (win_len !== 6'd11) $display("FAIL single win_len: got %0d want 11", win_len); else passed++;
        total++; if (tap_value !== 5'd15) $display("FAIL single tap_value: got %0d want 15", tap_value); else passed++;
        total++; if (done !== 1'b1 || fail !== 1'b0) $display("FAIL single done/fail: got %0b/%0b want 1/0", done, fail); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL single busy: got %0b want 0", busy); else passed++;
        total++; if (loads != 33) $display("FAIL single load count: got %0d want 33", loads); else passed++;
    endtask

    // Taps 3..6 and 20..27; a start pulse mid-sweep must be ignored.
    task automatic test_two_windows();
        int loads;
        int l0;
        retrain(32'h0FF0_0078);
        l0 = load_cnt;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("two", loads);
        loads = load_cnt - l0;
        total++; if (win_start !== 5'd20) $display("FAIL two win_start: got %0d want 20", win_start); else passed++;
        total++; if (win_len !== 6'd8) $display("FAIL two win_len: got %0d want 8", win_len); else passed++;
        total++; if (tap_value !== 5'd24) $display("FAIL two tap_value: got %0d want 24", tap_value); else passed++;
        total++; if (loads != 33) $display("FAIL start ignored load count: got %0d want 33", loads); else passed++;
    endtask

    task automatic test_tie();
        int loads;
        retrain(32'h001F_80FC);
        wait_result("tie", loads);
        total++; if (win_start !== 5'd2) $display("FAIL tie win_start: got %0d want 2", win_start); else passed++;
        total++; if (win_len !== 6'd6) $display("FAIL tie win_len: got %0d want 6", win_len); else passed++;
        total++; if (tap_value !== 5'd5) $display("FAIL tie tap_value: got %0d want 5", tap_value); else passed++;
    endtask

    task automatic test_last_tap();
        int loads;
        retrain(32'hFE00_0000);
        wait_result("edge", loads);
        total++; if (win_start !== 5'd25) $display("FAIL edge win_start: got %0d want 25", win_start); else passed++;
        total++; if (win_len !== 6'd7) $display("FAIL edge win_len: got %0d want 7", win_len); else passed++;
        total++; if (tap_value !== 5'd28) $display("FAIL edge tap_value: got %0d want 28", tap_value); else passed++;
    endtask

    task automatic test_fail_then_retrain();
        int loads;
        retrain(32'h0000_0700);
        wait_result("narrow", loads);
        total++; if (fail !== 1'b1) $display("FAIL narrow fail: got %0b want 1", fail); else passed++;
        total++; if (done !== 1'b0) $display("FAIL narrow done: got %0b want 0", done); else passed++;
        total++; if (tap_value !== 5'd0) $display("FAIL narrow tap_value: got %0d want 0", tap_value); else passed++;
        retrain(32'h0000_1F00);
        total++; if (fail !== 1'b0) $display("FAIL start clears fail: got %0b want 0", fail); else passed++;
        wait_result("retrain", loads);
        total++; if (done !== 1'b1 || fail !== 1'b0) $display("FAIL retrain done/fail: got %0b/%0b want 1/0", done, fail); else passed++;
        total++; if (tap_value !== 5'd10) $display("FAIL retrain tap_value: got %0d want 10", tap_value); else passed++;
    endtask

    task automatic test_ready_drop();
        int  loads;
        int  l0;
        bit  seen;
        retrain(32'h001F_FC00);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (tap_load && tap_value == 5'd12) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) $display("FAIL drop reach tap12: got no load of 12 want one"); else passed++;
        @(negedge clk);
        ctrl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL drop busy: got %0b want 0", busy); else passed++;
        l0 = load_cnt;
        repeat (30) @(negedge clk);
        total++; if (load_cnt != l0) $display("FAIL drop extra loads: got %0d want 0", load_cnt - l0); else passed++;
        total++; if (tap_value !== 5'd12) $display("FAIL drop tap_value kept: got %0d want 12", tap_value); else passed++;
        total++; if (done !== 1'b0 || fail !== 1'b0) $display("FAIL drop done/fail: got %0b/%0b want 0/0", done, fail); else passed++;
        ctrl_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (tap_load) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen || tap_value !== 5'd0) $display("FAIL restart tap: got seen=%0b tap=%0d want 1/0", seen, tap_value); else passed++;
        wait_result("restart", loads);
        total++; if (done !== 1'b1) $display("FAIL restart done: got %0b want 1", done); else passed++;
        total++; if (tap_value !== 5'd15) $display("FAIL restart tap_value: got %0d want 15", tap_value); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_two_windows();
        test_tie();
        test_last_tap();
        test_fail_then_retrain();
        test_ready_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
